// File: rtl/seg7_ctrl_pkg.sv
// Shared types and constants for the 7-segment
// counter sequencing controller.
package seg7_ctrl_pkg;

    localparam int STEP_W = 5;
    localparam int MEM_W  = 7;

    localparam logic [STEP_W-1:0] STEP_MIN = 5'd1;
    localparam logic [STEP_W-1:0] STEP_MAX = 5'd31;

    typedef enum logic [1:0] {
        SET,
        RUN,
        PAUSE
    } ctrl_state_t;

endpackage

// File: rtl/seg7_count_ctrl_if.sv
// Operator keys in, step/count/status out, between
// the key panel and the counter controller.
interface seg7_count_ctrl_if;
    import seg7_ctrl_pkg::*;

    logic              key_inc;
    logic              key_dec;
    logic              key_start;
    logic              key_pause;
    logic              key_stop;
    logic [STEP_W-1:0] counter_settings;
    logic [MEM_W-1:0]  memory;
    logic              run;
    logic              paused;
    logic              wrap_pulse;

    modport master (
        output key_inc, key_dec, key_start,
        output key_pause, key_stop,
        input  counter_settings, memory,
        input  run, paused, wrap_pulse
    );

    modport slave (
        input  key_inc, key_dec, key_start,
        input  key_pause, key_stop,
        output counter_settings, memory,
        output run, paused, wrap_pulse
    );

endinterface

// File: rtl/key_sync_edge.sv
// Two-flop key synchronizer with a one-cycle
// rising-edge pulse; a key held through reset is not a press.
module key_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic rise
);

    logic       s1;
    logic       s2;
    logic       prev;
    logic [1:0] fill;

    // Sync chain; prev stays high until s2 holds a real sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b1;
            fill <= 2'b00;
        end else begin
            s1   <= key;
            s2   <= s1;
            fill <= {fill[0], 1'b1};
            prev <= fill[1] ? s2 : 1'b1;
        end
    end

    assign rise = s2 & ~prev & fill[1];

endmodule

// File: rtl/seg7_count_ctrl.sv
// Step/accumulate sequencer: SET/RUN/PAUSE FSM,
// step register, tick prescaler and wrapping accumulator.
module seg7_count_ctrl
    import seg7_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int MEM_MAX  = 99
) (
    input  logic clock,
    input  logic reset,
    seg7_count_ctrl_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] SUM_MAX  = 8'(MEM_MAX);
    localparam logic [7:0] WRAP_SUB = 8'(MEM_MAX + 1);

    logic inc_e;
    logic dec_e;
    logic start_e;
    logic pause_e;
    logic stop_e;

    key_sync_edge u_inc (
        .clock(clock), .reset(reset),
        .key(bus.key_inc), .rise(inc_e)
    );
    key_sync_edge u_dec (
        .clock(clock), .reset(reset),
        .key(bus.key_dec), .rise(dec_e)
    );
    key_sync_edge u_start (
        .clock(clock), .reset(reset),
        .key(bus.key_start), .rise(start_e)
    );
    key_sync_edge u_pause (
        .clock(clock), .reset(reset),
        .key(bus.key_pause), .rise(pause_e)
    );
    key_sync_edge u_stop (
        .clock(clock), .reset(reset),
        .key(bus.key_stop), .rise(stop_e)
    );

    ctrl_state_t       state_q;
    ctrl_state_t       state_n;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_n;
    logic [MEM_W-1:0]  mem_q;
    logic [MEM_W-1:0]  mem_n;
    logic [PW-1:0]     presc_q;
    logic [PW-1:0]     presc_n;
    logic              wrap_q;
    logic              wrap_n;
    logic              run_q;
    logic              paused_q;
    logic              tick;
    logic [7:0]        sum;

    // All state and registered outputs advance together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= SET;
            step_q   <= STEP_MIN;
            mem_q    <= '0;
            presc_q  <= '0;
            wrap_q   <= 1'b0;
            run_q    <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            step_q   <= step_n;
            mem_q    <= mem_n;
            presc_q  <= presc_n;
            wrap_q   <= wrap_n;
            run_q    <= (state_n != SET);
            paused_q <= (state_n == PAUSE);
        end
    end

    // Next state; key priority is stop > start > pause > inc/dec.
    always_comb begin
        state_n = state_q;
        step_n  = step_q;
        mem_n   = mem_q;
        presc_n = presc_q;
        wrap_n  = 1'b0;
        tick    = 1'b0;
        sum     = {1'b0, mem_q} + {3'b000, step_q};
        unique case (state_q)
            SET: begin
                if (stop_e) begin
                    state_n = SET;
                end else if (start_e) begin
                    mem_n   = '0;
                    presc_n = '0;
                    state_n = RUN;
                end else if (!pause_e) begin
                    if (inc_e && !dec_e && step_q != STEP_MAX)
                        step_n = step_q + 5'd1;
                    else if (dec_e && !inc_e && step_q != STEP_MIN)
                        step_n = step_q - 5'd1;
                end
            end
            RUN: begin
                tick    = (presc_q == PRE_LAST);
                presc_n = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (sum > SUM_MAX) begin
                        mem_n  = MEM_W'(sum - WRAP_SUB);
                        wrap_n = 1'b1;
                    end else begin
                        mem_n  = MEM_W'(sum);
                    end
                end
                if (stop_e)
                    state_n = SET;
                else if (!start_e && pause_e)
                    state_n = PAUSE;
            end
            PAUSE: begin
                if (stop_e)
                    state_n = SET;
                else if (!start_e && pause_e)
                    state_n = RUN;
            end
            default: state_n = SET;
        endcase
    end

    assign bus.counter_settings = step_q;
    assign bus.memory           = mem_q;
    assign bus.run              = run_q;
    assign bus.paused           = paused_q;
    assign bus.wrap_pulse       = wrap_q;

endmodule

// File: tb/tb_seg7_count_ctrl.sv
// Directed bench for seg7_count_ctrl with TICK_DIV=4,
// MEM_MAX=99; all outputs sampled 1 time unit after posedge.
module tb_seg7_count_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    seg7_count_ctrl_if bus ();

    seg7_count_ctrl #(
        .TICK_DIV(4),
        .MEM_MAX(99)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [4:0] K_INC   = 5'b00001;
    localparam logic [4:0] K_DEC   = 5'b00010;
    localparam logic [4:0] K_START = 5'b00100;
    localparam logic [4:0] K_PAUSE = 5'b01000;
    localparam logic [4:0] K_STOP  = 5'b10000;

    task automatic set_keys(input logic [4:0] k);
        bus.key_inc   = k[0];
        bus.key_dec   = k[1];
        bus.key_start = k[2];
        bus.key_pause = k[3];
        bus.key_stop  = k[4];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [4:0] k);
        set_keys(k);
        step(3);
        set_keys(5'b0);
        step(3);
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        set_keys(5'b0);
        reset = 1'b0;
        step(3);
        obs = {bus.counter_settings, bus.run, bus.paused,
               bus.wrap_pulse, bus.memory};
        n_total++;
        if (obs !== {5'd1, 3'b000, 7'd0})
            $display("FAIL reset_hold: got %h want %h",
                     obs, {5'd1, 3'b000, 7'd0});
        else n_pass++;
        reset = 1'b1;
        step(2);
        obs = {bus.counter_settings, bus.run, bus.paused,
               bus.wrap_pulse, bus.memory};
        n_total++;
        if (obs !== {5'd1, 3'b000, 7'd0})
            $display("FAIL reset_release: got %h want %h",
                     obs, {5'd1, 3'b000, 7'd0});
        else n_pass++;
    endtask

    task automatic test_step();
        repeat (3) press(K_INC);
        press(K_DEC);
        n_total++;
        if (bus.counter_settings !== 5'd3)
            $display("FAIL step_3: got %0d want 3",
                     bus.counter_settings);
        else n_pass++;
        repeat (40) press(K_INC);
        n_total++;
        if (bus.counter_settings !== 5'd31)
            $display("FAIL step_sat_hi: got %0d want 31",
                     bus.counter_settings);
        else n_pass++;
        repeat (40) press(K_DEC);
        n_total++;
        if (bus.counter_settings !== 5'd1)
            $display("FAIL step_sat_lo: got %0d want 1",
                     bus.counter_settings);
        else n_pass++;
        repeat (6) press(K_INC);
        n_total++;
        if (bus.counter_settings !== 5'd7)
            $display("FAIL step_7: got %0d want 7",
                     bus.counter_settings);
        else n_pass++;
    endtask

    task automatic test_run_timing();
        logic [9:0] obs;
        logic [9:0] exp;
        int em;
        set_keys(K_START);
        for (int i = 1; i <= 11; i++) begin
            step(1);
            if (i == 2) set_keys(5'b0);
            em  = (i < 7) ? 0 : 7 * ((i - 3) / 4);
            exp = {(i >= 3), 1'b0, 1'b0, 7'(em)};
            obs = {bus.run, bus.paused, bus.wrap_pulse, bus.memory};
            n_total++;
            if (obs !== exp)
                $display("FAIL run_timing c%0d: got %h want %h",
                         i, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        logic [9:0] obs;
        logic [9:0] exp;
        int em;
        set_keys(K_PAUSE);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            if (i == 2) set_keys(5'b0);
            exp = {1'b1, (i == 3), 1'b0, 7'd14};
            obs = {bus.run, bus.paused, bus.wrap_pulse, bus.memory};
            n_total++;
            if (obs !== exp)
                $display("FAIL pause_enter c%0d: got %h want %h",
                         i, obs, exp);
            else n_pass++;
        end
        for (int i = 1; i <= 20; i++) begin
            step(1);
            exp = {1'b1, 1'b1, 1'b0, 7'd14};
            obs = {bus.run, bus.paused, bus.wrap_pulse, bus.memory};
            n_total++;
            if (obs !== exp)
                $display("FAIL pause_hold c%0d: got %h want %h",
                         i, obs, exp);
            else n_pass++;
        end
        set_keys(K_PAUSE);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (i == 2) set_keys(5'b0);
            em  = (i < 4) ? 14 : (i < 8) ? 21 : 28;
            exp = {1'b1, (i < 3), 1'b0, 7'(em)};
            obs = {bus.run, bus.paused, bus.wrap_pulse, bus.memory};
            n_total++;
            if (obs !== exp)
                $display("FAIL pause_resume c%0d: got %h want %h",
                         i, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_stop();
        logic [9:0] obs;
        logic [9:0] exp;
        set_keys(K_STOP);
        for (int i = 1; i <= 13; i++) begin
            step(1);
            if (i == 2) set_keys(5'b0);
            exp = {(i < 3), 1'b0, 1'b0, 7'd28};
            obs = {bus.run, bus.paused, bus.wrap_pulse, bus.memory};
            n_total++;
            if (obs !== exp)
                $display("FAIL stop_keep c%0d: got %h want %h",
                         i, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [9:0] obs;
        logic [9:0] exp;
        int tbl [5];
        int em;
        tbl = '{0, 31, 62, 93, 24};
        repeat (24) press(K_INC);
        n_total++;
        if (bus.counter_settings !== 5'd31)
            $display("FAIL wrap_step: got %0d want 31",
                     bus.counter_settings);
        else n_pass++;
        set_keys(K_START);
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (i == 2) set_keys(5'b0);
            em  = (i < 3) ? 28 : tbl[(i - 3) / 4];
            exp = {(i >= 3), 1'b0, (i == 19), 7'(em)};
            obs = {bus.run, bus.paused, bus.wrap_pulse, bus.memory};
            n_total++;
            if (obs !== exp)
                $display("FAIL wrap_seq c%0d: got %h want %h",
                         i, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_start_stop();
        logic [9:0] obs;
        logic [9:0] exp;
        int em;
        set_keys(K_START | K_STOP);
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (i == 2) set_keys(5'b0);
            em  = (i < 3) ? 24 : 55;
            exp = {(i < 3), 1'b0, 1'b0, 7'(em)};
            obs = {bus.run, bus.paused, bus.wrap_pulse, bus.memory};
            n_total++;
            if (obs !== exp)
                $display("FAIL start_stop c%0d: got %h want %h",
                         i, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_inc_dec();
        press(K_DEC);
        n_total++;
        if (bus.counter_settings !== 5'd30)
            $display("FAIL dec_30: got %0d want 30",
                     bus.counter_settings);
        else n_pass++;
        press(K_INC | K_DEC);
        n_total++;
        if (bus.counter_settings !== 5'd30)
            $display("FAIL inc_dec_same: got %0d want 30",
                     bus.counter_settings);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [14:0] obs;
        repeat (5) press(K_DEC);
        n_total++;
        if (bus.counter_settings !== 5'd25)
            $display("FAIL step_25: got %0d want 25",
                     bus.counter_settings);
        else n_pass++;
        set_keys(K_START);
        for (int i = 1; i <= 11; i++) begin
            step(1);
            if (i == 2) set_keys(5'b0);
        end
        n_total++;
        if ({bus.run, bus.memory} !== {1'b1, 7'd50})
            $display("FAIL mem_50: got %h want %h",
                     {bus.run, bus.memory}, {1'b1, 7'd50});
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        obs = {bus.counter_settings, bus.run, bus.paused,
               bus.wrap_pulse, bus.memory};
        n_total++;
        if (obs !== {5'd1, 3'b000, 7'd0})
            $display("FAIL async_reset: got %h want %h",
                     obs, {5'd1, 3'b000, 7'd0});
        else n_pass++;
    endtask

    task automatic test_held_key();
        set_keys(K_INC);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(10);
        n_total++;
        if (bus.counter_settings !== 5'd1)
            $display("FAIL held_key: got %0d want 1",
                     bus.counter_settings);
        else n_pass++;
        set_keys(5'b0);
        step(3);
        press(K_INC);
        n_total++;
        if (bus.counter_settings !== 5'd2)
            $display("FAIL repress: got %0d want 2",
                     bus.counter_settings);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_timing();
        test_pause();
        test_stop();
        test_wrap();
        test_start_stop();
        test_inc_dec();
        test_async_reset();
        test_held_key();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_count_ctrl.md
# seg7_count_ctrl

Sequencing controller for the 7-segment counter display. Generates the 5-bit step setting and the 7-bit accumulated count that the display path renders on two 3-digit groups. Operator keys adjust the step in SET, start, pause or stop an accumulation run, and a prescaled tick drives `memory += counter_settings` with wrap-around. All outputs are registered, so they drive the display path directly.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per accumulation tick; must be ≥2.
- `MEM_MAX`, default 99: largest `memory` value; must satisfy 31 ≤ MEM_MAX ≤ 127.
- `clock` input, 1 bit: single clock; all state is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `key_inc` input, 1 bit: asynchronous level, active-high; increments the step.
- `key_dec` input, 1 bit: asynchronous level, active-high; decrements the step.
- `key_start` input, 1 bit: asynchronous level, active-high; starts a run.
- `key_pause` input, 1 bit: asynchronous level, active-high; toggles pause.
- `key_stop` input, 1 bit: asynchronous level, active-high; ends the run.
- `counter_settings` output, 5 bits: step value, range 1..31.
- `memory` output, 7 bits: accumulated count, range 0..MEM_MAX.
- `run` output, 1 bit: high in RUN or PAUSE.
- `paused` output, 1 bit: high in PAUSE.
- `wrap_pulse` output, 1 bit: one-cycle pulse when `memory` wraps.

## Operation
- Each key passes through a 2-FF synchronizer and then a rising-edge detector. Only one action is taken per press; holding a key has no further effect.
- **FSM states:** SET (reset state), RUN, PAUSE.
- **SET:**
  - inc: `counter_settings + 1`, saturating at 31.
  - dec: `counter_settings - 1`, saturating at 1.
  - inc and dec in the same cycle: no change.
  - start: clears `memory` and the prescaler, then goes to RUN.
  - pause and stop: ignored.
- **RUN:**
  - The prescaler counts 0..TICK_DIV-1. On the terminal count it raises `tick` and reloads to 0.
  - On tick, form the 8-bit sum = `memory + counter_settings`.
  - If sum > MEM_MAX: `memory` = sum − (MEM_MAX+1) and `wrap_pulse` = 1 for that cycle.
  - Otherwise `memory` = sum.
  - pause goes to PAUSE; stop goes to SET; inc, dec and start are ignored.
- **PAUSE:**
  - The prescaler and `memory` hold.
  - pause goes back to RUN and the prescaler resumes from its held value.
  - stop goes to SET; inc, dec and start are ignored.
- **Key priority in a single cycle:** stop > start > pause > inc/dec.
- Stop keeps `memory` unchanged, so the last result stays on the display.
- A tick and stop in the same cycle: the tick's `memory` update is applied and the state goes to SET.
- **Reset values:** `counter_settings` = 1, `memory` = 0, `run` = 0, `paused` = 0, `wrap_pulse` = 0, state = SET. The prescaler and synchronizers clear to 0.
- Asserting reset mid-run aborts the run immediately and asynchronously.
- Width rule: sum ≤ 127 + 31 = 158, so it fits in 8 bits. Because step ≤ 31 ≤ MEM_MAX+1, a single subtraction always brings the result back into range.

## Timing
- Key path:
  - edge 1: sync1 captures the high key.
  - edge 2: sync2 captures it and the edge detector fires combinationally.
  - edge 3: state and outputs update.
  - Key-to-output latency is 3 cycles.
- First tick lands TICK_DIV cycles after the edge that enters RUN; later ticks follow every TICK_DIV cycles.
- `wrap_pulse` is high for exactly the cycle after the wrapping tick edge, aligned with the new `memory`.
- The `run` and `paused` outputs change on the same edge as the state register.

## Structure
- Package `seg7_ctrl_pkg` holds:
  - state enum `ctrl_state_t` {SET, RUN, PAUSE}
  - constants `STEP_MIN` = 1, `STEP_MAX` = 31
  - widths `STEP_W` = 5, `MEM_W` = 7
- Sub-module `key_sync_edge` (2-FF synchronizer plus rising-edge detector) is instantiated five times, once per key.
- The top level contains the FSM, the step register, the prescaler and the accumulator.

## Test plan
- Reset, then 3 inc presses and 1 dec press -> `counter_settings` = 3. Then 40 inc presses -> saturates at 31. Then 40 dec presses -> saturates at 1.
- With TICK_DIV = 4 and step = 7, press start -> `memory` goes 0, 7, 14, … with a tick every 4 cycles; the first update lands 4 cycles after entering RUN.
- With MEM_MAX = 99 and step = 31, run -> `memory` sequence 31, 62, 93, 24, with `wrap_pulse` high for one cycle together with 24.
- With `memory` = 14, press pause -> `memory` holds for 20 cycles with `paused` = 1. Press pause again -> the next tick arrives after the remaining prescaler count, not a full TICK_DIV.
- Press start and stop in the same cycle during RUN -> state is SET. Press inc and dec together in SET -> `counter_settings` unchanged. Press stop -> `memory` is retained.
- Assert reset mid-run with `memory` = 50 -> all outputs return to reset values immediately, without waiting for a clock edge. Hold a key high through reset release -> no action until the key is released and pressed again.
